// File: rtl/scg_burst_ap.sv
// rtl/scg_burst_ap.sv - burst read/write with auto-precharge command sequence FSM
//
// Issues one READA (2) or WRITEA (3) per start request, then paces CAS
// latency, the data burst and write-recovery/precharge before signalling done.
// Optional feature macro: SCG_WRITE_EN (write sequences; otherwise reads only).
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   start    request level, held until done is seen
//   write    access type sampled with start in IDLE (1 = write)
//   command  SDRAM command code: 0 NOP, 2 READA, 3 WRITEA
//   chip     data-beat strobe (capture read data / drive write data)
//   beat     current beat index, 0 when chip is low
//   busy     high outside IDLE
//   done     sequence complete, held until start falls
module scg_burst_ap #(
    parameter int CAS_LAT   = 3,
    parameter int BURST_LEN = 4,
    parameter int T_WR      = 2,
    parameter int T_RP      = 2,
    localparam int BW       = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          write,
    output logic [3:0]    command,
    output logic          chip,
    output logic [BW-1:0] beat,
    output logic          busy,
    output logic          done
);

    localparam int M1 = (CAS_LAT > BURST_LEN) ? CAS_LAT : BURST_LEN;
    localparam int MX = (M1 > (T_WR + T_RP)) ? M1 : (T_WR + T_RP);
    localparam int CW = $clog2(MX) + 1;

    localparam logic [CW-1:0] CNT_CAS   = CW'(CAS_LAT - 1);
    localparam logic [CW-1:0] CNT_RDATA = CW'(BURST_LEN - 1);
    // Write beat 0 goes out with the command, so DATA covers one beat fewer.
    localparam logic [CW-1:0] CNT_WDATA = CW'((BURST_LEN > 1) ? BURST_LEN - 2 : 0);
    localparam logic [CW-1:0] CNT_RP    = CW'(T_RP - 1);
    localparam logic [CW-1:0] CNT_WREC  = CW'(T_WR + T_RP - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CMD   = 3'd1,
        WAIT  = 3'd2,
        DATA  = 3'd3,
        RECOV = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [BW-1:0]  beat_q, beat_d;
    logic           wr_q, wr_d;
    logic           write_s;

`ifdef SCG_WRITE_EN
    assign write_s = write;
`else
    // Reads only: the port stays for a uniform interface but is ignored.
    logic unused_write;
    assign unused_write = write;
    assign write_s      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            beat_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            beat_q  <= beat_d;
            wr_q    <= wr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        beat_d  = beat_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    wr_d    = write_s;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (wr_q) begin
                    if (BURST_LEN == 1) begin
                        state_d = RECOV;
                        cnt_d   = CNT_WREC;
                    end else begin
                        state_d = DATA;
                        cnt_d   = CNT_WDATA;
                        beat_d  = BW'(1);
                    end
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_CAS;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DATA;
                    cnt_d   = CNT_RDATA;
                    beat_d  = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DATA: begin
                beat_d = beat_q + BW'(1);
                if (cnt_q == '0) begin
                    state_d = RECOV;
                    cnt_d   = wr_q ? CNT_WREC : CNT_RP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RECOV: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs: decoded from registered state only.
    assign command = (state_q == CMD) ? (wr_q ? 4'd3 : 4'd2) : 4'd0;
    assign chip    = (state_q == DATA) || ((state_q == CMD) && wr_q);
    assign beat    = (state_q == DATA) ? beat_q : '0;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_scg_burst_ap.sv
// tb/tb_scg_burst_ap.sv - table-driven self-checking bench for scg_burst_ap
module tb_scg_burst_ap;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, write_a = 1'b0;
    logic       start_b = 1'b0, write_b = 1'b0;
    logic [3:0] command_a, command_b;
    logic       chip_a, chip_b, busy_a, busy_b, done_a, done_b;
    logic [1:0] beat_a;
    logic [0:0] beat_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    scg_burst_ap dut_a (
        .clk(clk), .rst(rst), .start(start_a), .write(write_a),
        .command(command_a), .chip(chip_a), .beat(beat_a),
        .busy(busy_a), .done(done_a)
    );

    scg_burst_ap #(.CAS_LAT(2), .BURST_LEN(1), .T_WR(2), .T_RP(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .write(write_b),
        .command(command_b), .chip(chip_b), .beat(beat_b),
        .busy(busy_b), .done(done_b)
    );

    typedef struct {
        logic       sel;
        logic       start;
        logic       write;
        logic [3:0] cmd;
        logic       chip;
        logic [1:0] beat;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic sel, logic st, logic wr, logic [3:0] cmd,
                               logic chip, logic [1:0] beat, logic busy, logic done);
        vec_t r;
        r.sel = sel; r.start = st; r.write = wr; r.cmd = cmd;
        r.chip = chip; r.beat = beat; r.busy = busy; r.done = done;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_out(input logic sel, input vec_t e, input string tag);
        if (sel == 1'b0) begin
            chk({tag, ".command"}, int'(command_a), int'(e.cmd));
            chk({tag, ".chip"},    int'(chip_a),    int'(e.chip));
            chk({tag, ".beat"},    int'(beat_a),    int'(e.beat));
            chk({tag, ".busy"},    int'(busy_a),    int'(e.busy));
            chk({tag, ".done"},    int'(done_a),    int'(e.done));
        end else begin
            chk({tag, ".command"}, int'(command_b), int'(e.cmd));
            chk({tag, ".chip"},    int'(chip_b),    int'(e.chip));
            chk({tag, ".beat"},    int'(beat_b),    int'(e.beat));
            chk({tag, ".busy"},    int'(busy_b),    int'(e.busy));
            chk({tag, ".done"},    int'(done_b),    int'(e.done));
        end
    endtask

    // Row i: inputs applied before edge i (edge 0 = IDLE samples start),
    // expected outputs observed after that edge.
    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].sel == 1'b0) begin
                start_a = tbl[i].start; write_a = tbl[i].write;
            end else begin
                start_b = tbl[i].start; write_b = tbl[i].write;
            end
            @(posedge clk);
            @(negedge clk);
            chk_out(tbl[i].sel, tbl[i], $sformatf("%s[%0d]", tag, i));
        end
    endtask

    task automatic fill_read(input logic w);
        tbl.delete();
        tbl.push_back(v(0, 1, w, 4'd2, 0, 0, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(v(0, 1, w, 0, 0, 0, 1, 0));
        for (int b = 0; b < 4; b++) tbl.push_back(v(0, 1, w, 0, 1, 2'(b), 1, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(v(0, 1, w, 0, 0, 0, 1, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(v(0, 1, w, 0, 0, 0, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    vec_t zero;

    initial begin
        zero = v(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state of both instances
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        chk_out(1'b0, zero, "reset_a");
        chk_out(1'b1, zero, "reset_b");
        rst = 1'b0;
        @(negedge clk);

        // Default read
        fill_read(1'b0);
        run_tbl("read");

`ifdef SCG_WRITE_EN
        // Default write: WRITEA carries beat 0
        tbl.delete();
        tbl.push_back(v(0, 1, 1, 4'd3, 1, 0, 1, 0));
        for (int b = 1; b < 4; b++) tbl.push_back(v(0, 1, 1, 0, 1, 2'(b), 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(v(0, 1, 1, 0, 0, 0, 1, 1));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0));
        run_tbl("write");
`else
        // Reads only: write=1 must give exactly the read sequence
        fill_read(1'b1);
        run_tbl("write_ignored");
`endif

        // CAS_LAT=2, BURST_LEN=1, T_RP=1 read
        tbl.delete();
        tbl.push_back(v(1, 1, 0, 4'd2, 0, 0, 1, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 1, 0, 0, 1, 0, 1, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 0));
        tbl.push_back(v(1, 1, 0, 0, 0, 0, 1, 1));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0));
        run_tbl("short");

        // start dropped before edge 3: sequence completes, done for one cycle
        begin
            int n_cmd = 0;
            int n_done = 0;
            for (int e = 0; e < 16; e++) begin
                start_a = (e < 3);
                write_a = 1'b0;
                @(posedge clk);
                @(negedge clk);
                if (command_a != 4'd0) n_cmd++;
                if (done_a) n_done++;
                if (e == 0)  chk("drop.cmd0", int'(command_a), 2);
                if (e == 10) chk("drop.done10", int'(done_a), 1);
                if (e == 11) chk("drop.idle11", int'(busy_a), 0);
            end
            chk("drop.n_cmd", n_cmd, 1);
            chk("drop.n_done", n_done, 1);
        end

        // Reset at cycle 6 of a read aborts; held start restarts at once
        start_a = 1'b1;
        write_a = 1'b0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst_mid.chip_before", int'(chip_a), 1);
        chk("rst_mid.beat_before", int'(beat_a), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_out(1'b0, zero, "rst_mid");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid.restart_cmd", int'(command_a), 2);
        start_a = 1'b0;
        begin
            int k = 0;
            while (busy_a && k < 30) begin
                @(posedge clk);
                @(negedge clk);
                k++;
            end
            chk("rst_mid.return_idle", int'(busy_a), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/scg_burst_ap.md
# scg_burst_ap

Parametrised burst read/write with auto-precharge command sequence FSM for the SDRAM controller. On a `start` request it issues one READA or WRITEA command, then paces CAS latency, the data burst and write-recovery/precharge. It signals completion with a level `done` held until the requester releases `start`. It sits beside the other command sequence generators (scg_*) and feeds the command mux and data-path strobe of the controller.

## Interface
- `CAS_LAT`, 3: read CAS latency in clocks; legal 1..7.
- `BURST_LEN`, 4: beats per access; legal 1, 2, 4, 8.
- `T_WR`, 2: write recovery clocks after the last write beat; legal 1..4.
- `T_RP`, 2: precharge clocks after the burst; legal 1..7.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `start`  in  1  request level; held high until `done` is seen.
- `write`  in  1  access type, sampled in IDLE with `start`: 1 = write, 0 = read.
- `command`  out  4  SDRAM command code: 0 = NOP, 2 = READA, 3 = WRITEA.
- `chip`  out  1  data-beat strobe: capture read data, or drive write data.
- `beat`  out  max(1,$clog2(BURST_LEN))  index of the current beat; 0 when `chip` = 0.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  sequence complete.

## Operation
- States: IDLE, CMD, WAIT, DATA, RECOV, DONE. A single down-counter `cnt` is shared by WAIT, DATA and RECOV.
- IDLE:
  - On `start` = 1, latch `write` into `wr_q` and go to CMD.
  - Otherwise stay in IDLE.
- CMD (1 cycle): `command` = 3 if `wr_q`, else 2.
  - Read: go to WAIT with `cnt` = CAS_LAT-1.
  - Write: `chip` = 1 and `beat` = 0 in this cycle.
    - If BURST_LEN = 1, go to RECOV with `cnt` = T_WR+T_RP-1.
    - Otherwise go to DATA with `cnt` = BURST_LEN-2.
- WAIT: used by reads only. Decrement `cnt`; at 0, go to DATA with `cnt` = BURST_LEN-1.
- DATA:
  - `chip` = 1; `beat` increments by 1 each cycle, continuing from the previous beat.
  - At `cnt` = 0, go to RECOV:
    - read: `cnt` = T_RP-1;
    - write: `cnt` = T_WR+T_RP-1.
- RECOV: decrement `cnt`; at 0, go to DONE.
- DONE: `done` = 1. Stay while `start` = 1; return to IDLE when `start` = 0.
- `command` = 0 in every state except CMD.
- Once CMD is issued, the sequence always runs to DONE. Dropping `start` mid-sequence does not abort it; DONE then lasts exactly 1 cycle.
- Back-to-back requests need `start` low for at least 1 cycle, which passes through IDLE. A new access is therefore never issued without a `start` rising edge.
- Counter width: `$clog2` of max(CAS_LAT, BURST_LEN, T_WR+T_RP), plus 1 bit. The counter never wraps.

## Timing
- Reset: on any rising edge with `rst` = 1, state goes to IDLE.
  - Reset values: `command` = 0, `chip` = 0, `beat` = 0, `busy` = 0, `done` = 0; `cnt` and `wr_q` are cleared.
  - Reset mid-sequence aborts immediately. The controller's init/refresh logic is responsible for SDRAM state afterwards.
- All outputs are decoded from registered state only (Moore). There is no combinational path from `start` to any output.
- Cycle numbering: cycle 0 is the edge where IDLE samples `start`.
- Read, defaults:
  - CMD at cycle 1; WAIT at cycles 2-4;
  - DATA at cycles 5-8 with `beat` 0..3;
  - RECOV at cycles 9-10; DONE from cycle 11.
  - General: first beat at cycle CAS_LAT+2; DONE at CAS_LAT+BURST_LEN+T_RP+2.
- Write, defaults:
  - CMD plus beat 0 at cycle 1; DATA beats 1..3 at cycles 2-4;
  - RECOV at cycles 5-8; DONE from cycle 9.
  - General: DONE at BURST_LEN+T_WR+T_RP+1.

## Configuration
- `SCG_WRITE_EN` defined: write sequences are supported as described above.
- `SCG_WRITE_EN` undefined:
  - the `write` port remains but is ignored, and `wr_q` is forced to 0;
  - every request is a READA sequence and `command` never equals 3.

## Test plan
- Reset, then `start` = 1, `write` = 0 with defaults → `command` = 2 at cycle 1 only; `chip` at cycles 5-8 with `beat` 0,1,2,3; `done` rises at cycle 11 and holds while `start` = 1; IDLE one cycle after `start` falls.
- With `SCG_WRITE_EN`, `start` = 1, `write` = 1 → `command` = 3 together with `chip` = 1, `beat` = 0 at cycle 1; beats 1-3 at cycles 2-4; `done` at cycle 9.
- CAS_LAT = 2, BURST_LEN = 1, T_RP = 1 read → `command` = 2 at cycle 1; single `chip` at cycle 4 with `beat` = 0; `done` at cycle 6.
- `start` dropped at cycle 3 of a default read → sequence completes unchanged; `done` is high for exactly cycle 11, IDLE at cycle 12; no second command.
- `rst` = 1 at cycle 6 of a default read → at the next edge all outputs read 0 and state is IDLE; a fresh `start` gives `command` = 2 one cycle later.
- Without `SCG_WRITE_EN`, `start` with `write` = 1 → read timing identical to the first scenario and `command` never equals 3.
